// File: rtl/ghrd_button_debounce.sv
// Per-channel 2-FF synchronizer, counter-based debouncer and rise/fall strobe generator
// for devkit push-buttons and DIP switches; clean_out feeds the input PIO directly.
module ghrd_button_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam logic             POL       = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [WIDTH-1:0] SYNC_INIT = {WIDTH{POL}};
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ACCEPT  = 2'd2
  } db_state_e;

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;
  logic [WIDTH-1:0] lvl_s;
  logic [CNT_W-1:0] cnt_r     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
  logic [WIDTH-1:0] clean_nxt_s;
  logic [WIDTH-1:0] rise_nxt_s;
  logic [WIDTH-1:0] fall_nxt_s;

  // Two-stage synchronizer; resets to the idle pad level so release cannot fake a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r <= SYNC_INIT;
      s2_r <= SYNC_INIT;
    end else begin
      s1_r <= raw_in;
      s2_r <= s1_r;
    end
  end

  assign lvl_s = s2_r ^ SYNC_INIT;

  // Per-channel classification and next-state/strobe computation.
  always_comb begin
    db_state_e st_v;
    st_v        = ST_IDLE;
    clean_nxt_s = clean_out;
    rise_nxt_s  = {WIDTH{1'b0}};
    fall_nxt_s  = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (lvl_s[i] == clean_out[i]) begin
        st_v = ST_IDLE;
      end else if (cnt_r[i] == CNT_LAST) begin
        st_v = ST_ACCEPT;
      end else begin
        st_v = ST_PENDING;
      end
      case (st_v)
        ST_IDLE: begin
          cnt_nxt_s[i] = CNT_ZERO;
        end
        ST_PENDING: begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
        end
        ST_ACCEPT: begin
          cnt_nxt_s[i]   = CNT_ZERO;
          clean_nxt_s[i] = lvl_s[i];
          rise_nxt_s[i]  = lvl_s[i];
          fall_nxt_s[i]  = ~lvl_s[i];
        end
        default: begin
          cnt_nxt_s[i] = CNT_ZERO;
        end
      endcase
    end
  end

  // Debounce state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      clean_out  <= {WIDTH{1'b0}};
      rise_pulse <= {WIDTH{1'b0}};
      fall_pulse <= {WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      clean_out  <= clean_nxt_s;
      rise_pulse <= rise_nxt_s;
      fall_pulse <= fall_nxt_s;
    end
  end

endmodule

// File: tb/tb_ghrd_button_debounce.sv
// Table-driven bench for ghrd_button_debounce with WIDTH=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1;
// each vector drives raw_in before an edge and checks the outputs 1 ns after it.
module tb_ghrd_button_debounce;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] raw_in;
  logic [3:0] clean_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] raw;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
    int         grp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  ghrd_button_debounce #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  task automatic chk(input string nm, input int idx, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [3:0] c, input logic [3:0] r,
                         input logic [3:0] f);
    chk({tag, " clean_out"}, idx, clean_out, c);
    chk({tag, " rise_pulse"}, idx, rise_pulse, r);
    chk({tag, " fall_pulse"}, idx, fall_pulse, f);
  endtask

  function automatic void add(input int n, input logic [3:0] r, input logic [3:0] c,
                              input logic [3:0] ri, input logic [3:0] f, input int g);
    vec_t v;
    v.raw = r; v.clean = c; v.rise = ri; v.fall = f; v.grp = g;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  initial begin
    reset_n = 1'b0;
    raw_in  = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 4'h0, 4'h0, 4'h0);
    reset_n = 1'b1;

    // 1: idle pads after reset
    add(20, 4'hF, 4'h0, 4'h0, 4'h0, 1);
    // 2: press ch0 (first vector is E0), accept at E0+5, then release
    add(5, 4'hE, 4'h0, 4'h0, 4'h0, 2);
    add(1, 4'hE, 4'h1, 4'h1, 4'h0, 2);
    add(3, 4'hE, 4'h1, 4'h0, 4'h0, 2);
    add(5, 4'hF, 4'h1, 4'h0, 4'h0, 2);
    add(1, 4'hF, 4'h0, 4'h0, 4'h1, 2);
    add(3, 4'hF, 4'h0, 4'h0, 4'h0, 2);
    // 3: bounce on ch1, acceptance 5 edges after the last 1->0 sample
    add(3, 4'hD, 4'h0, 4'h0, 4'h0, 3);
    add(1, 4'hF, 4'h0, 4'h0, 4'h0, 3);
    add(5, 4'hD, 4'h0, 4'h0, 4'h0, 3);
    add(1, 4'hD, 4'h2, 4'h2, 4'h0, 3);
    add(3, 4'hD, 4'h2, 4'h0, 4'h0, 3);
    add(5, 4'hF, 4'h2, 4'h0, 4'h0, 3);
    add(1, 4'hF, 4'h0, 4'h0, 4'h2, 3);
    add(2, 4'hF, 4'h0, 4'h0, 4'h0, 3);
    // 4: glitches of 1, 2 and 3 cycles on ch2 never get through
    add(1, 4'hB, 4'h0, 4'h0, 4'h0, 4);
    add(6, 4'hF, 4'h0, 4'h0, 4'h0, 4);
    add(2, 4'hB, 4'h0, 4'h0, 4'h0, 4);
    add(6, 4'hF, 4'h0, 4'h0, 4'h0, 4);
    add(3, 4'hB, 4'h0, 4'h0, 4'h0, 4);
    add(8, 4'hF, 4'h0, 4'h0, 4'h0, 4);
    // 5: ch0 and ch3 together
    add(5, 4'h6, 4'h0, 4'h0, 4'h0, 5);
    add(1, 4'h6, 4'h9, 4'h9, 4'h0, 5);
    add(2, 4'h6, 4'h9, 4'h0, 4'h0, 5);
    add(5, 4'hF, 4'h9, 4'h0, 4'h0, 5);
    add(1, 4'hF, 4'h0, 4'h0, 4'h9, 5);
    add(2, 4'hF, 4'h0, 4'h0, 4'h0, 5);

    for (int i = 0; i < vecs.size(); i++) begin
      raw_in = vecs[i].raw;
      @(posedge clk);
      #1;
      chk_all($sformatf("grp%0d", vecs[i].grp), i, vecs[i].clean, vecs[i].rise, vecs[i].fall);
    end

    // 6: reset asserted at E0+3 of a ch0 press, pad held throughout
    raw_in = 4'hE;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_all("rst_pre", k, 4'h0, 4'h0, 4'h0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk_all("rst_async", 0, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk_all("rst_hold", k, 4'h0, 4'h0, 4'h0);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      chk_all("rst_after", k, (k >= 6) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0, 4'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
